// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings,
// instruction field bounds and PC constants.
package fetch_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t REQ   = 3'd1;
  localparam state_t WAIT  = 3'd2;
  localparam state_t HOLD  = 3'd3;
  localparam state_t FLUSH = 3'd4;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational redirect decision and target computation from the
// resolve-stage decode fields; shared with the future pipelined fetch.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic        resolve_valid,
  input  logic        ctl_branch,
  input  logic        ctl_bne,
  input  logic        ctl_jump,
  input  logic        alu_zero,
  input  logic [15:0] imm16,
  input  logic [25:0] jtarget26,
  input  logic [31:0] res_pc_plus4,
  output logic        redirect,
  output logic [31:0] target
);

  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  // Branch offset is a signed word count, so sign-extend then scale by 4.
  assign branch_offset = {{14{imm16[15]}}, imm16, 2'b00};
  assign branch_target = res_pc_plus4 + branch_offset;
  assign jump_target   = {res_pc_plus4[31:28], jtarget26, 2'b00};

  assign redirect = resolve_valid & (ctl_jump | (ctl_branch & (alu_zero ^ ctl_bne)));
  assign target   = ctl_jump ? jump_target : branch_target;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding word read at
// a time, hands instructions to decode and squashes stale responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  opcode,
  input  logic        resolve_valid,
  input  logic        ctl_branch,
  input  logic        ctl_bne,
  input  logic        ctl_jump,
  input  logic        alu_zero,
  input  logic [15:0] imm16,
  input  logic [25:0] jtarget26,
  input  logic [31:0] res_pc_plus4
);

  state_t      state;
  logic [31:0] fetch_pc;
  logic        redirect;
  logic [31:0] target;

  next_pc_calc u_next_pc_calc (
    .resolve_valid (resolve_valid),
    .ctl_branch    (ctl_branch),
    .ctl_bne       (ctl_bne),
    .ctl_jump      (ctl_jump),
    .alu_zero      (alu_zero),
    .imm16         (imm16),
    .jtarget26     (jtarget26),
    .res_pc_plus4  (res_pc_plus4),
    .redirect      (redirect),
    .target        (target)
  );

  // A redirect in REQ suppresses the strobe so the wrong-path read is never issued.
  assign imem_req  = (state == REQ) && !redirect;
  assign imem_addr = fetch_pc;
  assign opcode    = instr[OPC_MSB:OPC_LSB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= REQ;

        REQ: begin
          if (redirect) fetch_pc <= target;
          else          state    <= WAIT;
        end

        WAIT: begin
          if (redirect) begin
            fetch_pc <= target;
            state    <= imem_valid ? REQ : FLUSH;
          end else if (imem_valid) begin
            instr       <= imem_rdata;
            instr_pc    <= fetch_pc;
            fetch_pc    <= fetch_pc + PC_INC;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end

        HOLD: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            fetch_pc    <= target;
            state       <= REQ;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= REQ;
          end
        end

        // The response to the squashed read is still owed; swallow it before reissuing.
        FLUSH: begin
          if (redirect)   fetch_pc <= target;
          if (imem_valid) state    <= REQ;
        end

        default: state <= IDLE;
      endcase
    end
  end

  a_no_unsolicited_rsp: assert property (@(posedge clk) disable iff (rst)
    imem_valid |-> (state == WAIT || state == FLUSH));

endmodule
